// File: rtl/conv1d_obi_regs.sv
// rtl/conv1d_obi_regs.sv - OBI register file for the conv1d accelerator
//
// conv1d_obi_pkg : OBI request/response struct types shared with the bus fabric.
// conv1d_obi_regs: OBI responder, one transaction in flight, 1-cycle response.
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   req_i / resp_o      OBI request (req, we, be, addr, wdata) / response (gnt, rvalid, rdata)
//   busy_i, done_i      datapath busy level and 1-cycle completion pulse
//   start_o             1-cycle start pulse to the datapath
//   src_addr_o, dst_addr_o, len_o, ksize_o   configuration registers
//   irq_o               level interrupt, DONE & IRQ_EN

package conv1d_obi_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module conv1d_obi_regs
    import conv1d_obi_pkg::*;
#(
    parameter logic [31:0] ID_VALUE = 32'hC01D_0001,
    parameter int          LEN_W    = 16,
    parameter int          KS_W     = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  obi_req_t         req_i,
    output obi_resp_t        resp_o,
    input  logic             busy_i,
    input  logic             done_i,
    output logic             start_o,
    output logic [31:0]      src_addr_o,
    output logic [31:0]      dst_addr_o,
    output logic [LEN_W-1:0] len_o,
    output logic [KS_W-1:0]  ksize_o,
    output logic             irq_o
);

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_STATUS = 3'd1;
    localparam logic [2:0] A_SRC    = 3'd2;
    localparam logic [2:0] A_DST    = 3'd3;
    localparam logic [2:0] A_LEN    = 3'd4;
    localparam logic [2:0] A_KSIZE  = 3'd5;
    localparam logic [2:0] A_ID     = 3'd6;

    logic             irq_en_q;
    logic             done_q;
    logic             start_q;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [LEN_W-1:0] len_q;
    logic [KS_W-1:0]  ksize_q;
    logic             rvalid_q;
    logic [31:0]      rdata_q;

    logic        accept;
    logic        wr;
    logic [2:0]  sel;
    logic [31:0] lane_mask;
    logic [31:0] len_ext;
    logic [31:0] ksize_ext;
    logic [31:0] len_next;
    logic [31:0] ksize_next;
    logic [31:0] rd_val;
    logic        unused_addr_bits;

    // Base decoding happens in the interconnect; only the word index matters here.
    assign unused_addr_bits = ^{req_i.addr[31:5], req_i.addr[1:0]};

    assign accept = req_i.req;
    assign wr     = accept & req_i.we;
    assign sel    = req_i.addr[4:2];

    assign lane_mask = {{8{req_i.be[3]}}, {8{req_i.be[2]}}, {8{req_i.be[1]}}, {8{req_i.be[0]}}};

    // Narrow registers are widened to 32 bits so the same byte-lane merge applies.
    always_comb begin
        len_ext                = '0;
        len_ext[LEN_W-1:0]     = len_q;
        ksize_ext              = '0;
        ksize_ext[KS_W-1:0]    = ksize_q;
        len_next               = (len_ext & ~lane_mask) | (req_i.wdata & lane_mask);
        ksize_next             = (ksize_ext & ~lane_mask) | (req_i.wdata & lane_mask);
    end

    always_comb begin
        rd_val = '0;
        unique case (sel)
            A_CTRL:   rd_val[1] = irq_en_q;
            A_STATUS: rd_val[1:0] = {done_q, busy_i};
            A_SRC:    rd_val = src_q;
            A_DST:    rd_val = dst_q;
            A_LEN:    rd_val = len_ext;
            A_KSIZE:  rd_val = ksize_ext;
            A_ID:     rd_val = ID_VALUE;
            default:  rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            ksize_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= accept;
            rdata_q  <= (accept && !req_i.we) ? rd_val : 32'h0;

            // A START seen while the datapath is busy is simply dropped.
            start_q  <= wr && (sel == A_CTRL) && req_i.be[0] && req_i.wdata[0] && !busy_i;

            if (wr && (sel == A_CTRL) && req_i.be[0]) begin
                irq_en_q <= req_i.wdata[1];
            end

            // Set has priority over a same-cycle clear so no completion is lost.
            if (done_i) begin
                done_q <= 1'b1;
            end else if (wr && (sel == A_STATUS) && req_i.be[0] && req_i.wdata[1]) begin
                done_q <= 1'b0;
            end

            if (wr && (sel == A_SRC)) begin
                src_q <= (src_q & ~lane_mask) | (req_i.wdata & lane_mask);
            end
            if (wr && (sel == A_DST)) begin
                dst_q <= (dst_q & ~lane_mask) | (req_i.wdata & lane_mask);
            end
            if (wr && (sel == A_LEN)) begin
                len_q <= len_next[LEN_W-1:0];
            end
            if (wr && (sel == A_KSIZE)) begin
                ksize_q <= ksize_next[KS_W-1:0];
            end
        end
    end

    assign resp_o.gnt    = req_i.req;
    assign resp_o.rvalid = rvalid_q;
    assign resp_o.rdata  = rdata_q;

    assign start_o    = start_q;
    assign src_addr_o = src_q;
    assign dst_addr_o = dst_q;
    assign len_o      = len_q;
    assign ksize_o    = ksize_q;
    assign irq_o      = done_q & irq_en_q;

endmodule

// File: tb/tb_conv1d_obi_regs.sv
// tb/tb_conv1d_obi_regs.sv - directed self-checking bench for conv1d_obi_regs
module tb_conv1d_obi_regs;
    import conv1d_obi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    obi_req_t    req;
    obi_resp_t   resp;
    logic        busy = 1'b0;
    logic        done = 1'b0;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic [3:0]  ksize;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    conv1d_obi_regs dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req),
        .resp_o     (resp),
        .busy_i     (busy),
        .done_i     (done),
        .start_o    (start),
        .src_addr_o (src_addr),
        .dst_addr_o (dst_addr),
        .len_o      (len),
        .ksize_o    (ksize),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered and left at 1 time unit after a rising edge; leaves rvalid cycle current.
    task automatic txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp, input string name);
        req.req   = 1'b1;
        req.we    = we;
        req.be    = be;
        req.addr  = addr;
        req.wdata = wdata;
        #1;
        check({name, " gnt"}, 32'(resp.gnt), 32'h1);
        @(posedge clk);
        #1;
        req = '0;
        check({name, " rvalid"}, 32'(resp.rvalid), 32'h1);
        check({name, " rdata"}, resp.rdata, exp);
    endtask

    function automatic vec_t mk(input logic we, input logic [3:0] be, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp);
        vec_t v;
        v.we = we; v.be = be; v.addr = addr; v.wdata = wdata; v.exp = exp;
        return v;
    endfunction

    initial begin
        req = '0;
        vecs.push_back(mk(1'b0, 4'hF, 32'h18, 32'h0, 32'hC01D_0001));
        vecs.push_back(mk(1'b0, 4'hF, 32'h08, 32'h0, 32'h0));
        vecs.push_back(mk(1'b1, 4'b0101, 32'h08, 32'hDEAD_BEEF, 32'h0));
        vecs.push_back(mk(1'b0, 4'hF, 32'h08, 32'h0, 32'h00AD_00EF));
        vecs.push_back(mk(1'b1, 4'hF, 32'h0C, 32'h1234_5678, 32'h0));
        vecs.push_back(mk(1'b0, 4'hF, 32'h0C, 32'h0, 32'h1234_5678));
        vecs.push_back(mk(1'b1, 4'b1100, 32'h10, 32'hFFFF_FFFF, 32'h0));
        vecs.push_back(mk(1'b0, 4'hF, 32'h10, 32'h0, 32'h0));
        vecs.push_back(mk(1'b1, 4'b0011, 32'h10, 32'hFFFF_ABCD, 32'h0));
        vecs.push_back(mk(1'b0, 4'hF, 32'h10, 32'h0, 32'h0000_ABCD));
        vecs.push_back(mk(1'b1, 4'hF, 32'h14, 32'hFFFF_FFFF, 32'h0));
        vecs.push_back(mk(1'b0, 4'hF, 32'h14, 32'h0, 32'h0000_000F));
        vecs.push_back(mk(1'b1, 4'hF, 32'h1C, 32'hFFFF_FFFF, 32'h0));
        vecs.push_back(mk(1'b0, 4'hF, 32'h1C, 32'h0, 32'h0));
        vecs.push_back(mk(1'b1, 4'b0000, 32'h00, 32'h0000_0002, 32'h0));
        vecs.push_back(mk(1'b0, 4'hF, 32'h00, 32'h0, 32'h0));
        vecs.push_back(mk(1'b0, 4'hF, 32'hABCD_0018, 32'h0, 32'hC01D_0001));
        vecs.push_back(mk(1'b0, 4'hF, 32'h0000_001B, 32'h0, 32'hC01D_0001));

        repeat (2) @(posedge clk);
        #1;
        check("reset rvalid", 32'(resp.rvalid), 32'h0);
        check("reset rdata", resp.rdata, 32'h0);
        check("reset start", 32'(start), 32'h0);
        check("reset irq", 32'(irq), 32'h0);
        check("reset src", src_addr, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            txn(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, vecs[i].exp,
                $sformatf("vec%0d", i));
        end
        check("src_addr_o", src_addr, 32'h00AD_00EF);
        check("dst_addr_o", dst_addr, 32'h1234_5678);
        check("len_o", 32'(len), 32'h0000_ABCD);
        check("ksize_o", 32'(ksize), 32'hF);

        // START while idle: exactly one cycle of start_o.
        check("start idle before", 32'(start), 32'h0);
        txn(1'b1, 4'hF, 32'h00, 32'h3, 32'h0, "ctrl start");
        check("start pulse", 32'(start), 32'h1);
        @(posedge clk);
        #1;
        check("start pulse end", 32'(start), 32'h0);
        check("rvalid drops", 32'(resp.rvalid), 32'h0);
        txn(1'b0, 4'hF, 32'h00, 32'h0, 32'h2, "ctrl readback");

        // START while busy is dropped.
        busy = 1'b1;
        txn(1'b1, 4'hF, 32'h00, 32'h3, 32'h0, "ctrl busy start");
        check("no start when busy", 32'(start), 32'h0);
        txn(1'b0, 4'hF, 32'h04, 32'h0, 32'h1, "status busy");
        busy = 1'b0;
        check("no late start", 32'(start), 32'h0);

        // DONE sets, raises irq, clears by W1C.
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        check("irq after done", 32'(irq), 32'h1);
        txn(1'b0, 4'hF, 32'h04, 32'h0, 32'h2, "status done");
        txn(1'b1, 4'b1110, 32'h04, 32'h2, 32'h0, "status clr no be0");
        check("irq kept without be0", 32'(irq), 32'h1);
        txn(1'b1, 4'hF, 32'h04, 32'h2, 32'h0, "status clr");
        check("irq cleared", 32'(irq), 32'h0);
        txn(1'b0, 4'hF, 32'h04, 32'h0, 32'h0, "status cleared");

        // Same-cycle set and clear: set wins.
        done = 1'b1;
        txn(1'b1, 4'hF, 32'h04, 32'h2, 32'h0, "status clr vs set");
        done = 1'b0;
        check("irq set wins", 32'(irq), 32'h1);
        txn(1'b0, 4'hF, 32'h04, 32'h0, 32'h2, "status set wins");

        // Back-to-back: write LEN, read LEN, read reserved.
        req.req = 1'b1; req.we = 1'b1; req.be = 4'hF; req.addr = 32'h10; req.wdata = 32'h40;
        @(posedge clk);
        #1;
        check("b2b0 rvalid", 32'(resp.rvalid), 32'h1);
        check("b2b0 rdata", resp.rdata, 32'h0);
        req.we = 1'b0; req.addr = 32'h10; req.wdata = 32'h0;
        @(posedge clk);
        #1;
        check("b2b1 rvalid", 32'(resp.rvalid), 32'h1);
        check("b2b1 rdata", resp.rdata, 32'h40);
        req.addr = 32'h1C;
        @(posedge clk);
        #1;
        check("b2b2 rvalid", 32'(resp.rvalid), 32'h1);
        check("b2b2 rdata", resp.rdata, 32'h0);
        req = '0;
        @(posedge clk);
        #1;
        check("b2b idle rvalid", 32'(resp.rvalid), 32'h0);
        check("b2b idle rdata", resp.rdata, 32'h0);

        // Reset right after a read is accepted squashes its response.
        req.req = 1'b1; req.we = 1'b0; req.be = 4'hF; req.addr = 32'h18;
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        check("rst gnt follows req", 32'(resp.gnt), 32'h1);
        req = '0;
        check("rst rvalid", 32'(resp.rvalid), 32'h0);
        check("rst rdata", resp.rdata, 32'h0);
        check("rst irq", 32'(irq), 32'h0);
        check("rst src", src_addr, 32'h0);
        check("rst dst", dst_addr, 32'h0);
        check("rst len", 32'(len), 32'h0);
        check("rst ksize", 32'(ksize), 32'h0);
        @(posedge clk);
        #1;
        check("rst rvalid held", 32'(resp.rvalid), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        txn(1'b0, 4'hF, 32'h04, 32'h0, 32'h0, "post-rst status");
        txn(1'b0, 4'hF, 32'h00, 32'h0, 32'h0, "post-rst ctrl");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
